// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: tick/button/switch inputs
// toward the controller, BCD digits and status back out.
interface stopwatch_ctrl_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       blink;
  logic       pause_p;
  logic       clear_p;
  logic       adj_sw;
  logic       sel_sw;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] blank;
  logic       running;
  logic       adjusting;

  modport master (
    output tick_1hz, tick_2hz, blink,
    output pause_p, clear_p, adj_sw, sel_sw,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  blank, running, adjusting
  );

  modport slave (
    input  tick_1hz, tick_2hz, blink,
    input  pause_p, clear_p, adj_sw, sel_sw,
    output min_tens, min_ones, sec_tens, sec_ones,
    output blank, running, adjusting
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: HOLD/RUN/ADJ sequencing of
// BCD MM:SS registers plus adjust-mode digit blanking.
module stopwatch_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  stopwatch_ctrl_if.slave    sw
);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    ADJ  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] min_q;
  logic [7:0] sec_q;
  logic [3:0] blank_q;
  logic       running_q;
  logic       adjusting_q;

  // adj_sw outranks pause_p outside ADJ
  function automatic state_t nxt(
    input state_t s,
    input logic   adj,
    input logic   pause
  );
    nxt = s;
    unique case (s)
      HOLD: if (adj) nxt = ADJ;
            else if (pause) nxt = RUN;
      RUN:  if (adj) nxt = ADJ;
            else if (pause) nxt = HOLD;
      ADJ:  if (!adj) nxt = HOLD;
      default: nxt = HOLD;
    endcase
  endfunction

  // {tens,ones} BCD, 59 wraps to 00
  function automatic logic [7:0] inc60(
    input logic [7:0] v
  );
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5)
        inc60 = 8'h00;
      else
        inc60 = {v[7:4] + 4'd1, 4'd0};
    end else begin
      inc60 = {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  state_t s_nx;
  assign s_nx = nxt(state, sw.adj_sw, sw.pause_p);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HOLD;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      blank_q     <= 4'b0000;
      running_q   <= 1'b0;
      adjusting_q <= 1'b0;
    end else begin
      state       <= s_nx;
      running_q   <= (s_nx == RUN);
      adjusting_q <= (s_nx == ADJ);
      if (s_nx == ADJ)
        blank_q <= sw.sel_sw ?
          {2'b00, {2{sw.blink}}} :
          {{2{sw.blink}}, 2'b00};
      else
        blank_q <= 4'b0000;

      // tick decisions use the state before this edge
      if (sw.clear_p) begin
        min_q <= 8'h00;
        sec_q <= 8'h00;
      end else if (state == RUN && sw.tick_1hz) begin
        sec_q <= inc60(sec_q);
        if (sec_q == 8'h59)
          min_q <= inc60(min_q);
      end else if (state == ADJ && sw.tick_2hz) begin
        if (sw.sel_sw)
          sec_q <= inc60(sec_q);
        else
          min_q <= inc60(min_q);
      end
    end
  end

  assign sw.min_tens  = min_q[7:4];
  assign sw.min_ones  = min_q[3:0];
  assign sw.sec_tens  = sec_q[7:4];
  assign sw.sec_ones  = sec_q[3:0];
  assign sw.blank     = blank_q;
  assign sw.running   = running_q;
  assign sw.adjusting = adjusting_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, corner
// sequences and random stimulus against a time model.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stopwatch_ctrl_if ifc ();

  stopwatch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (ifc.slave)
  );

  typedef struct {
    logic r, p, c, a, s, t1, t2, b;
    int   emin;
    int   esec;
    logic [3:0] ebl;
    logic er;
    logic ea;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // model: mode 0 hold, 1 run, 2 adjust
  int m_mode = 0;
  int m_min = 0;
  int m_sec = 0;
  logic [3:0] m_blank = 4'b0;

  function automatic vec_t mk(
    input logic r, p, c, a, s, t1, t2, b,
    input int emin, esec,
    input logic [3:0] ebl,
    input logic er, ea
  );
    vec_t v;
    v.r = r; v.p = p; v.c = c; v.a = a;
    v.s = s; v.t1 = t1; v.t2 = t2; v.b = b;
    v.emin = emin; v.esec = esec;
    v.ebl = ebl; v.er = er; v.ea = ea;
    return v;
  endfunction

  function automatic logic [21:0] pack(
    input int mn, sc,
    input logic [3:0] bl,
    input logic r, a
  );
    return {4'(mn / 10), 4'(mn % 10),
            4'(sc / 10), 4'(sc % 10),
            bl, r, a};
  endfunction

  function automatic logic [21:0] dut_word();
    return {ifc.min_tens, ifc.min_ones,
            ifc.sec_tens, ifc.sec_ones,
            ifc.blank, ifc.running, ifc.adjusting};
  endfunction

  task automatic model_step(input vec_t v);
    int prev;
    int tot;
    prev = m_mode;
    if (!v.r) begin
      m_mode = 0; m_min = 0; m_sec = 0;
      m_blank = 4'b0;
    end else begin
      if (prev == 2)
        m_mode = v.a ? 2 : 0;
      else if (v.a)
        m_mode = 2;
      else if (v.p)
        m_mode = (prev == 1) ? 0 : 1;
      if (v.c) begin
        m_min = 0; m_sec = 0;
      end else if (prev == 1 && v.t1) begin
        tot = (m_min * 60 + m_sec + 1) % 3600;
        m_min = tot / 60;
        m_sec = tot % 60;
      end else if (prev == 2 && v.t2) begin
        if (v.s) m_sec = (m_sec + 1) % 60;
        else     m_min = (m_min + 1) % 60;
      end
      if (m_mode == 2 && v.b)
        m_blank = v.s ? 4'b0011 : 4'b1100;
      else
        m_blank = 4'b0000;
    end
  endtask

  task automatic cmp(input string name,
                     input logic [21:0] exp);
    vectors++;
    if (dut_word() !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h",
               name, dut_word(), exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n        = v.r;
    ifc.pause_p  = v.p;
    ifc.clear_p  = v.c;
    ifc.adj_sw   = v.a;
    ifc.sel_sw   = v.s;
    ifc.tick_1hz = v.t1;
    ifc.tick_2hz = v.t2;
    ifc.blink    = v.b;
    @(posedge clk);
    #1;
    model_step(v);
    cmp("model", pack(m_min, m_sec, m_blank,
                      m_mode == 1, m_mode == 2));
  endtask

  task automatic drv(input logic p, c, a, s, t1, t2, b);
    apply(mk(1'b1, p, c, a, s, t1, t2, b,
             0, 0, 4'b0, 1'b0, 1'b0));
  endtask

  task automatic expect_out(input string name,
                            input int mn, sc,
                            input logic [3:0] bl,
                            input logic r, a);
    cmp(name, pack(mn, sc, bl, r, a));
  endtask

  vec_t tbl[$];

  initial begin
    logic a_l, s_l, b_l;
    rst_n = 1'b0;
    ifc.pause_p = 0; ifc.clear_p = 0;
    ifc.adj_sw = 0; ifc.sel_sw = 0;
    ifc.tick_1hz = 0; ifc.tick_2hz = 0;
    ifc.blink = 0;

    //             r p c a s t1 t2 b  min sec blank  run adj
    tbl.push_back(mk(0,1,0,1,1,1,1,1, 0, 0, 4'b0000,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,0,1, 0, 0, 4'b0000,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,0, 0, 0, 4'b0000,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0,0, 0, 0, 4'b0000,1,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,0, 0, 1, 4'b0000,1,0));
    tbl.push_back(mk(1,1,0,0,0,1,0,0, 0, 2, 4'b0000,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,0, 0, 2, 4'b0000,0,0));
    tbl.push_back(mk(1,1,0,1,0,0,1,1, 0, 2, 4'b1100,0,1));
    tbl.push_back(mk(1,0,0,1,0,0,1,0, 1, 2, 4'b0000,0,1));
    tbl.push_back(mk(1,1,0,1,1,0,0,1, 1, 2, 4'b0011,0,1));
    tbl.push_back(mk(1,0,0,1,1,0,1,1, 1, 3, 4'b0011,0,1));
    tbl.push_back(mk(1,0,1,1,1,0,1,1, 0, 0, 4'b0011,0,1));
    tbl.push_back(mk(1,0,0,0,1,0,1,1, 0, 1, 4'b0000,0,0));
    tbl.push_back(mk(1,1,0,0,0,1,0,0, 0, 1, 4'b0000,1,0));
    tbl.push_back(mk(1,0,1,0,0,1,0,0, 0, 0, 4'b0000,1,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,0, 0, 1, 4'b0000,1,0));
    tbl.push_back(mk(1,0,0,1,0,1,0,0, 0, 2, 4'b0000,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0, 2, 4'b0000,0,0));

    foreach (tbl[i]) begin
      apply(tbl[i]);
      expect_out($sformatf("tbl%0d", i),
                 tbl[i].emin, tbl[i].esec,
                 tbl[i].ebl, tbl[i].er, tbl[i].ea);
    end

    // reset, then five ticks while holding
    apply(mk(0,0,0,0,0,0,0,0, 0,0,4'b0,0,0));
    for (int i = 0; i < 5; i++)
      drv(0,0,0,0,1,0,0);
    expect_out("hold_ticks", 0, 0, 4'b0, 0, 0);

    // preload 00:59, run one tick -> 01:00
    drv(0,1,0,0,0,0,0);
    drv(0,0,1,1,0,0,0);
    for (int i = 0; i < 59; i++)
      drv(0,0,1,1,0,1,0);
    expect_out("pre_0059", 0, 59, 4'b0, 0, 1);
    drv(0,0,0,0,0,0,0);
    drv(1,0,0,0,0,0,0);
    drv(0,0,0,0,1,0,0);
    expect_out("carry_0100", 1, 0, 4'b0, 1, 0);
    drv(1,0,0,0,0,0,0);

    // minutes wrap at 59 without touching seconds
    drv(0,1,0,0,0,0,0);
    drv(0,0,1,0,0,0,0);
    for (int i = 0; i < 61; i++)
      drv(0,0,1,0,0,1,0);
    expect_out("adj_min61", 1, 0, 4'b0, 0, 1);
    drv(0,0,1,0,0,0,1);
    expect_out("blank_min", 1, 0, 4'b1100, 0, 1);
    drv(0,0,1,1,0,0,1);
    expect_out("blank_sec", 1, 0, 4'b0011, 0, 1);
    drv(0,0,0,1,0,0,1);
    expect_out("adj_exit", 1, 0, 4'b0000, 0, 0);

    // 59:59 + 1 s -> 00:00
    drv(0,0,1,0,0,0,0);
    for (int i = 0; i < 58; i++)
      drv(0,0,1,0,0,1,0);
    for (int i = 0; i < 59; i++)
      drv(0,0,1,1,0,1,0);
    expect_out("pre_5959", 59, 59, 4'b0, 0, 1);
    drv(0,0,0,0,0,0,0);
    drv(1,0,0,0,0,0,0);
    drv(0,0,0,0,1,0,0);
    expect_out("wrap_5959", 0, 0, 4'b0, 1, 0);
    drv(1,0,0,0,0,0,0);

    // clear beats tick at 12:34 while running
    drv(0,1,0,0,0,0,0);
    drv(0,0,1,0,0,0,0);
    for (int i = 0; i < 12; i++)
      drv(0,0,1,0,0,1,0);
    for (int i = 0; i < 34; i++)
      drv(0,0,1,1,0,1,0);
    drv(0,0,0,0,0,0,0);
    drv(1,0,0,0,0,0,0);
    expect_out("run_1234", 12, 34, 4'b0, 1, 0);
    drv(0,1,0,0,1,0,0);
    expect_out("clr_prio", 0, 0, 4'b0, 1, 0);
    drv(0,0,0,0,1,0,0);
    expect_out("clr_next", 0, 1, 4'b0, 1, 0);

    // pause coincident with tick is counted
    for (int i = 0; i < 9; i++)
      drv(0,0,0,0,1,0,0);
    drv(1,0,0,0,1,0,0);
    expect_out("pause_tick", 0, 11, 4'b0, 0, 0);
    for (int i = 0; i < 3; i++)
      drv(0,0,0,0,1,0,0);
    expect_out("hold_0011", 0, 11, 4'b0, 0, 0);

    // random traffic against the model
    a_l = 0; s_l = 0; b_l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) a_l = ~a_l;
      if ($urandom_range(9) == 0)  s_l = ~s_l;
      if ($urandom_range(4) == 0)  b_l = ~b_l;
      apply(mk($urandom_range(99) != 0,
               $urandom_range(15) == 0,
               $urandom_range(39) == 0,
               a_l, s_l,
               $urandom_range(3) == 0,
               $urandom_range(2) == 0,
               b_l,
               0, 0, 4'b0, 1'b0, 1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
